// File: rtl/morse_digit_writer_if.sv
// Morse key input and six-digit display buffer bundle between the key front end and the display.
interface morse_digit_writer_if;
  logic       key;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit4;
  logic [3:0] digit5;
  logic       digit_valid;
  logic [2:0] elem_count;
  logic       key_db;

  modport master (
    output key,
    input  digit0, digit1, digit2, digit3, digit4, digit5,
    input  digit_valid, elem_count, key_db
  );

  modport slave (
    input  key,
    output digit0, digit1, digit2, digit3, digit4, digit5,
    output digit_valid, elem_count, key_db
  );
endinterface

// File: rtl/morse_digit_writer.sv
// Debounces a Morse key, classifies presses as dots/dashes and decodes five-element digits
// into a six-digit shift buffer; digit_valid fires GAP_CYCLES+1 cycles after the final release.
module morse_digit_writer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] DOT_MAX_CYCLES  = 24'd10000000,
  parameter logic [23:0] GAP_CYCLES      = 24'd20000000
) (
  input  logic               clk,
  input  logic               rst,
  morse_digit_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t      state_q;
  logic        sync1_q, sync2_q, key_db_q;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic [23:0] press_cnt_q, gap_cnt_q, gap_cnt_d;
  logic [4:0]  pattern_q;
  logic [2:0]  elem_cnt_q;
  logic [3:0]  digit_q [6];
  logic        digit_valid_q;
  logic        elem_bit;
  logic [3:0]  decoded_d;

  assign db_cnt_d  = db_cnt_q + 16'd1;
  assign gap_cnt_d = gap_cnt_q + 24'd1;
  assign elem_bit  = (press_cnt_q > DOT_MAX_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      key_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= bus.key;
      sync2_q <= sync1_q;
      if (sync2_q == key_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_d >= DEBOUNCE_CYCLES) begin
        key_db_q <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_d;
      end
    end
  end

  // Pattern holds elements oldest-at-bit-4; only full five-element digits decode.
  always_comb begin
    decoded_d = 4'hE;
    if (elem_cnt_q == 3'd5) begin
      case (pattern_q)
        5'b01111: decoded_d = 4'd1;
        5'b00111: decoded_d = 4'd2;
        5'b00011: decoded_d = 4'd3;
        5'b00001: decoded_d = 4'd4;
        5'b00000: decoded_d = 4'd5;
        5'b10000: decoded_d = 4'd6;
        5'b11000: decoded_d = 4'd7;
        5'b11100: decoded_d = 4'd8;
        5'b11110: decoded_d = 4'd9;
        5'b11111: decoded_d = 4'd0;
        default:  decoded_d = 4'hE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      press_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      pattern_q     <= '0;
      elem_cnt_q    <= '0;
      digit_valid_q <= 1'b0;
      for (int i = 0; i < 6; i++) digit_q[i] <= 4'hF;
    end else begin
      digit_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_db_q) begin
            state_q     <= PRESS;
            press_cnt_q <= 24'd1;
          end
        end
        PRESS: begin
          // press_cnt_q equals the number of debounced-high cycles seen so far
          if (key_db_q) begin
            if (press_cnt_q != {24{1'b1}}) press_cnt_q <= press_cnt_q + 24'd1;
          end else begin
            state_q   <= GAP;
            gap_cnt_q <= '0;
            if (elem_cnt_q < 3'd5) begin
              pattern_q  <= {pattern_q[3:0], elem_bit};
              elem_cnt_q <= elem_cnt_q + 3'd1;
            end else begin
              elem_cnt_q <= 3'd6;
            end
          end
        end
        GAP: begin
          if (key_db_q) begin
            state_q     <= PRESS;
            press_cnt_q <= 24'd1;
          end else if (gap_cnt_d >= GAP_CYCLES) begin
            state_q       <= IDLE;
            gap_cnt_q     <= '0;
            digit_valid_q <= 1'b1;
            pattern_q     <= '0;
            elem_cnt_q    <= '0;
            for (int i = 5; i > 0; i--) digit_q[i] <= digit_q[i-1];
            digit_q[0]    <= decoded_d;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.digit0      = digit_q[0];
  assign bus.digit1      = digit_q[1];
  assign bus.digit2      = digit_q[2];
  assign bus.digit3      = digit_q[3];
  assign bus.digit4      = digit_q[4];
  assign bus.digit5      = digit_q[5];
  assign bus.digit_valid = digit_valid_q;
  assign bus.elem_count  = elem_cnt_q;
  assign bus.key_db      = key_db_q;
endmodule
